// File: rtl/io_input_conditioner.sv
// Input conditioner for board switches and pushbuttons: per-bit two-flop
// synchronizer, saturating debounce counter, and key press pulse/event flags.
module io_input_conditioner #(
  parameter int unsigned DEBOUNCE_COUNT = 50000,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] switchesRaw,
  input  logic [3:0] keysRaw,
  input  logic [3:0] clearEvents,
  output logic [9:0] switches,
  output logic [3:0] keys,
  output logic [3:0] keyPulse,
  output logic [3:0] keyEvents
);

  localparam int NumBits = 14;
  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_COUNT - 1);
  // Synchronizers hold raw polarity; key bits idle high (released).
  localparam logic [NumBits-1:0] SyncRst = {4'hF, 10'h000};

  logic [NumBits-1:0]   sync1_q, sync2_q;
  logic [NumBits-1:0]   cond;
  logic [NumBits-1:0]   db_q, db_d;
  logic [CNT_WIDTH-1:0] cnt_q [NumBits];
  logic [CNT_WIDTH-1:0] cnt_d [NumBits];
  logic [3:0]           key_rise;
  logic [3:0]           pulse_q, pulse_d;
  logic [3:0]           events_q, events_d;

  // Two-flop synchronizer for all raw inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= SyncRst;
      sync2_q <= SyncRst;
    end else begin
      sync1_q <= {keysRaw, switchesRaw};
      sync2_q <= sync1_q;
    end
  end

  // Keys become active-high after synchronization.
  assign cond = {~sync2_q[13:10], sync2_q[9:0]};

  // Per-bit debounce: count consecutive disagreements, update on the last one.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NumBits; i++) begin
      cnt_d[i] = '0;
      if (cond[i] != db_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          db_d[i] = cond[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Press detection on the debounced key levels; a press beats a clear.
  always_comb begin
    key_rise = db_d[13:10] & ~db_q[13:10];
    pulse_d  = key_rise;
    events_d = (events_q & ~clearEvents) | key_rise;
  end

  // Debounce state and key flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q     <= '0;
      pulse_q  <= '0;
      events_q <= '0;
      for (int i = 0; i < NumBits; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q     <= db_d;
      pulse_q  <= pulse_d;
      events_q <= events_d;
      for (int i = 0; i < NumBits; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign switches  = db_q[9:0];
  assign keys      = db_q[13:10];
  assign keyPulse  = pulse_q;
  assign keyEvents = events_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner with DEBOUNCE_COUNT = 4: directed scenarios
// with literal expectations plus randomized stimulus against a window model.
module tb_io_input_conditioner;

  localparam int Dc = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] switchesRaw = '0;
  logic [3:0] keysRaw = 4'hF;
  logic [3:0] clearEvents = '0;
  logic [9:0] switches;
  logic [3:0] keys, keyPulse, keyEvents;

  int vectors = 0;
  int miscompares = 0;

  io_input_conditioner #(
    .DEBOUNCE_COUNT(Dc),
    .CNT_WIDTH     (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .switchesRaw(switchesRaw),
    .keysRaw    (keysRaw),
    .clearEvents(clearEvents),
    .switches   (switches),
    .keys       (keys),
    .keyPulse   (keyPulse),
    .keyEvents  (keyEvents)
  );

  always #5 clk = ~clk;

  // Model: d(k) is the active-high input sampled two edges before edge k
  // (reset value before that). A bit flips at edge n when d disagreed with
  // the debounced value on each of the last Dc edges, all after its last flip.
  logic [13:0] hist[$];
  int          n;
  int          last_flip[14];
  logic [13:0] mq;
  logic [3:0]  mp, me;

  task automatic model_reset();
    hist = {};
    hist.push_back(14'h0);
    hist.push_back(14'h0);
    n = 0;
    for (int b = 0; b < 14; b++) last_flip[b] = 0;
    mq = '0;
    mp = '0;
    me = '0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_reset();
      end else begin
        logic [13:0] nq;
        logic [3:0]  rise;
        n++;
        hist.push_back({~keysRaw, switchesRaw});
        nq = mq;
        for (int b = 0; b < 14; b++) begin
          if (n - Dc + 1 > last_flip[b]) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int k = n - Dc + 1; k <= n; k++) begin
              if (hist[k-1][b] == mq[b]) all_diff = 1'b0;
            end
            if (all_diff) begin
              nq[b] = ~mq[b];
              last_flip[b] = n;
            end
          end
        end
        rise = nq[13:10] & ~mq[13:10];
        mp = rise;
        me = (me & ~clearEvents) | rise;
        mq = nq;
      end
    end
  end

  // Cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      if ({keyEvents, keyPulse, keys, switches} !== {me, mp, mq[13:10], mq[9:0]}) begin
        miscompares++;
        $display("FAIL cycle t=%0t: got ev=%h pu=%h k=%h sw=%h expected ev=%h pu=%h k=%h sw=%h",
                 $time, keyEvents, keyPulse, keys, switches, me, mp, mq[13:10], mq[9:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  logic [13:0] r;
  int          hold[14];

  initial begin
    // Reset state and switch latency.
    switchesRaw = 10'h2A5;
    #12;
    chk("reset_outputs", {keyEvents, keyPulse, keys, switches}, 32'h0);
    nxt();
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      nxt();
      chk($sformatf("sw_latency_e%0d", k), switches, (k < 6) ? 32'h0 : 32'h2A5);
    end

    // Clean press of key 0, then release.
    keysRaw[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      nxt();
      chk($sformatf("key0_e%0d", k), {keyEvents[0], keyPulse[0], keys},
          {30'h0, (k >= 6), (k == 6)} << 4 | ((k >= 6) ? 32'h1 : 32'h0));
    end
    keysRaw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) nxt();
    chk("key0_release", {keyEvents, keyPulse, keys}, 32'h100);

    // Bouncing key 1 never debounces.
    for (int rep = 0; rep < 5; rep++) begin
      keysRaw[1] = 1'b0;
      for (int k = 0; k < 3; k++) nxt();
      chk("key1_bounce_lo", {keyEvents[1], keyPulse[1], keys[1]}, 32'h0);
      keysRaw[1] = 1'b1;
      for (int k = 0; k < 3; k++) nxt();
      chk("key1_bounce_hi", {keyEvents[1], keyPulse[1], keys[1]}, 32'h0);
    end

    // Key 2: set event, then press again with a simultaneous clear.
    keysRaw[2] = 1'b0;
    for (int k = 0; k < 6; k++) nxt();
    keysRaw[2] = 1'b1;
    for (int k = 0; k < 6; k++) nxt();
    chk("key2_event_set", {keyEvents[2], keys[2]}, 32'h2);
    keysRaw[2] = 1'b0;
    for (int k = 0; k < 5; k++) nxt();
    clearEvents = 4'b0100;
    nxt();
    chk("key2_set_wins", {keyEvents[2], keyPulse[2], keys[2]}, 32'h7);
    clearEvents = 4'b0000;
    nxt();
    clearEvents = 4'b0100;
    nxt();
    chk("key2_cleared", {keyEvents[2], keyEvents[0]}, 32'h1);
    clearEvents = 4'b0000;
    keysRaw[2] = 1'b1;
    for (int k = 0; k < 6; k++) nxt();

    // Reset mid-count discards progress on switch 3.
    switchesRaw[3] = 1'b1;
    for (int k = 0; k < 4; k++) nxt();
    reset_n = 1'b0;
    #1;
    chk("reset_async", {keyEvents, keyPulse, keys, switches}, 32'h0);
    nxt();
    nxt();
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      nxt();
      chk($sformatf("sw3_after_reset_e%0d", k), switches, (k < 6) ? 32'h0 : 32'h2AD);
    end

    // Randomized traffic with one reset pulse in the middle.
    r = {keysRaw, switchesRaw};
    for (int b = 0; b < 14; b++) hold[b] = $urandom_range(1, 9);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      nxt();
      for (int b = 0; b < 14; b++) begin
        if (hold[b] == 0) begin
          if ($urandom_range(0, 1) == 1) r[b] = ~r[b];
          hold[b] = $urandom_range(1, 9);
        end else begin
          hold[b]--;
        end
      end
      switchesRaw = r[9:0];
      keysRaw     = r[13:10];
      for (int i = 0; i < 4; i++) clearEvents[i] = ($urandom_range(0, 7) == 0);
      if (cyc == 1500) reset_n = 1'b0;
      if (cyc == 1503) reset_n = 1'b1;
    end

    nxt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

Interface
REQ-001 The block SHALL take parameter DEBOUNCE_COUNT, default 50000, meaning consecutive clock edges a synchronized input must disagree with its debounced value before that value updates (1 ms at 50 MHz); legal range 1 to 65535.
REQ-002 The block SHALL take parameter CNT_WIDTH, default 16, meaning the width of each per-bit debounce counter; it must hold DEBOUNCE_COUNT-1.
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port switchesRaw  input  10  raw board slide switches, asynchronous, active-high.
REQ-006 Port keysRaw  input  4  raw board pushbuttons, asynchronous, active-low (0 = pressed).
REQ-007 Port clearEvents  input  4  per-key clear strobe for keyEvents, synchronous.
REQ-008 Port switches  output  10  debounced switch levels, active-high; feeds the IO memory switch register.
REQ-009 Port keys  output  4  debounced key levels, active-high (1 = pressed); feeds the IO memory key register.
REQ-010 Port keyPulse  output  4  one-cycle press strobe per key.
REQ-011 Port keyEvents  output  4  sticky press flags per key.

Function
REQ-012 Each of the 14 inputs SHALL pass through its own two-flop synchronizer; key bits SHALL be inverted after synchronization so all downstream logic is active-high.
REQ-013 Each bit SHALL have an independent CNT_WIDTH counter and debounced register q; no state is shared between bits.
REQ-014 Per edge: sync2 == q -> counter <= 0, q holds.
REQ-015 Per edge: sync2 != q and counter < DEBOUNCE_COUNT-1 -> counter increments, q holds.
REQ-016 Per edge: sync2 != q and counter == DEBOUNCE_COUNT-1 -> q <= sync2, counter <= 0.
REQ-017 Latency: with the first rising edge that samples a new, stable raw value numbered edge 1, q SHALL change on edge DEBOUNCE_COUNT+2, never earlier.
REQ-018 Any return to agreement before the count completes (bounce, glitch) SHALL zero the counter; q SHALL not change, and the next disagreement restarts counting from 0.
REQ-019 DEBOUNCE_COUNT = 1 SHALL give q updating on edge 3 (synchronizer delay only plus one edge).
REQ-020 Counters SHALL never exceed DEBOUNCE_COUNT-1 and SHALL never wrap.
REQ-021 keyPulse[i] SHALL be 1 for exactly the first cycle in which keys[i] is 1 after a 0->1 transition; release (1->0) SHALL produce no pulse.
REQ-022 keyEvents[i] SHALL set on the same edge that keys[i] rises and SHALL hold until cleared.
REQ-023 clearEvents[i] = 1 at an edge SHALL clear keyEvents[i] on that edge.
REQ-024 Set and clear on the same edge SHALL leave keyEvents[i] = 1 (set wins; no press lost).
REQ-025 Switches SHALL generate no pulses or events.
REQ-026 Multiple bits changing on the same edge SHALL be processed independently and simultaneously.

Reset
REQ-027 reset_n = 0 SHALL immediately and asynchronously force: switch synchronizers 0, key synchronizers to released (raw 1), all counters 0, switches 0, keys 0, keyPulse 0, keyEvents 0.
REQ-028 Reset asserted mid-count SHALL discard the count; after release, debouncing restarts from edge 1 per REQ-017.
REQ-029 A switch held on through reset SHALL appear on switches at edge DEBOUNCE_COUNT+2 after release, with no event generated.
REQ-030 A key held through reset SHALL be reported as a fresh press (keyPulse, keyEvents) once debounced after release.

Verification (DEBOUNCE_COUNT = 4)
REQ-031 Reset, then drive switchesRaw = 10'h2A5 steady from edge 1 -> switches = 0 through edge 5, switches = 10'h2A5 from edge 6.
REQ-032 keysRaw[0] 1->0 steady -> keys = 4'b0001 from edge 6; keyPulse[0] = 1 for one cycle only; keyEvents[0] = 1 and remains after keysRaw[0] returns to 1.
REQ-033 keysRaw[1] low for 3 cycles then high, repeated 5 times -> keys[1], keyPulse[1] and keyEvents[1] stay 0 throughout.
REQ-034 keyEvents[2] = 1; assert clearEvents[2] on the same edge that a new debounced press of key 2 completes -> keyEvents[2] stays 1; clearEvents[2] alone on a later edge -> 0 next cycle.
REQ-035 Assert reset_n = 0 after 2 disagreeing edges of switchesRaw[3] -> outputs 0 immediately; after release, switches[3] rises at edge 6, not earlier.
